// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the RV32I core.
// Holds the PC, fetches one instruction at a time over a req/gnt/rvalid
// handshake and presents the registered instruction to main_decoder.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, a retire
// whose next PC is not word aligned parks the unit in TRAP until reset.
// Without it, the next PC is forced to word alignment and Misalign is 0.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] ImmExt,
    input  logic            StallD,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            InstrValid,
    output logic [31:0]     Instr,
    output logic [6:0]      op,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            Misalign
);

`ifdef MISALIGN_TRAP_EN
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, TRAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
`endif

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic            req_q;
    logic            valid_q;
    logic [XLEN-1:0] targetPc;
    logic [XLEN-1:0] nextPc_d;
    logic            retire;

    // Next PC: branch target or fall-through, both wrapping mod 2^XLEN.
    // Without the trap feature the low two bits are cleared so the PC
    // can never leave word alignment.
    always_comb begin
        targetPc = PCSrc ? (pc_q + ImmExt) : (pc_q + PC_STEP);
`ifdef MISALIGN_TRAP_EN
        nextPc_d = targetPc;
`else
        nextPc_d = targetPc & ~XLEN'(3);
`endif
    end

    // An instruction leaves the stage when it is valid and decode can take it.
    assign retire = valid_q & ~StallD;

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;

    // Fetch FSM with registered handshake/valid/trap outputs; a response
    // arriving outside WAIT (for example after a reset mid-fetch) is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                end
                REQ: begin
                    if (imem_gnt) begin
                        state_q <= WAIT;
                        req_q   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        instr_q <= imem_rdata;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (retire) begin
                        pc_q    <= nextPc_d;
                        valid_q <= 1'b0;
                        if (nextPc_d[1:0] != 2'b00) begin
                            state_q    <= TRAP;
                            misalign_q <= 1'b1;
                        end else begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                        end
                    end
                end
                TRAP: begin
                    state_q <= TRAP;
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign Misalign = misalign_q;
`else
    // Fetch FSM with registered handshake/valid outputs; a response
    // arriving outside WAIT (for example after a reset mid-fetch) is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                end
                REQ: begin
                    if (imem_gnt) begin
                        state_q <= WAIT;
                        req_q   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        instr_q <= imem_rdata;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (retire) begin
                        pc_q    <= nextPc_d;
                        valid_q <= 1'b0;
                        state_q <= REQ;
                        req_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign Misalign = 1'b0;
`endif

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign InstrValid = valid_q;
    assign Instr      = instr_q;
    assign op         = instr_q[6:0];
    assign PC         = pc_q;
    assign PCPlus4    = pc_q + PC_STEP;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// The bench plays instruction memory and decode. Directed rows come from a
// table, followed by reset/misalign sequences and a randomized run whose
// expected PC stream is computed from plain address arithmetic.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        PCSrc;
    logic [31:0] ImmExt;
    logic        StallD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [6:0]  op;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        Misalign;

    int totalChecks;
    int passedChecks;

    typedef struct {
        logic [31:0] word;
        int          gntDelay;
        int          rvDelay;
        int          stallCycles;
        logic        src;
        logic [31:0] imm;
        logic [31:0] expPC;
        logic [31:0] expNext;
        logic        expTrap;
    } vec_t;

    vec_t tbl[9];

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .PCSrc       (PCSrc),
        .ImmExt      (ImmExt),
        .StallD      (StallD),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .InstrValid  (InstrValid),
        .Instr       (Instr),
        .op          (op),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .Misalign    (Misalign)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalChecks++;
        if (act === exp) passedChecks++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One instruction through the stage: request, grant, response, hold, retire.
    task automatic applyStimulus(input vec_t v);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("reqSeen", {31'b0, imem_req}, 32'd1);
        checkOutput("fetchAddr", imem_addr, v.expPC);
        for (int i = 0; i < v.gntDelay; i++) begin
            imem_gnt    = 1'b0;
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            tick();
            checkOutput("reqHeld", {31'b0, imem_req}, 32'd1);
            checkOutput("addrStable", imem_addr, v.expPC);
        end
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b1;
        tick();
        imem_gnt = 1'b0;
        checkOutput("reqDropAfterGnt", {31'b0, imem_req}, 32'd0);
        for (int i = 0; i < v.rvDelay; i++) begin
            tick();
            checkOutput("noValidInWait", {31'b0, InstrValid}, 32'd0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = v.word;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        checkOutput("instrValid", {31'b0, InstrValid}, 32'd1);
        checkOutput("instr", Instr, v.word);
        checkOutput("op", {25'b0, op}, {25'b0, v.word[6:0]});
        checkOutput("pc", PC, v.expPC);
        checkOutput("pcPlus4", PCPlus4, v.expPC + 32'd4);
        for (int i = 0; i < v.stallCycles; i++) begin
            StallD      = 1'b1;
            PCSrc       = 1'($urandom_range(0, 1));
            ImmExt      = $urandom;
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            tick();
            checkOutput("stallInstr", Instr, v.word);
            checkOutput("stallPc", PC, v.expPC);
            checkOutput("stallNoReq", {31'b0, imem_req}, 32'd0);
        end
        imem_rvalid = 1'b0;
        StallD      = 1'b0;
        PCSrc       = v.src;
        ImmExt      = v.imm;
        tick();
        PCSrc  = 1'($urandom_range(0, 1));
        ImmExt = $urandom;
        checkOutput("validDropAfterRetire", {31'b0, InstrValid}, 32'd0);
        if (v.expTrap) begin
            checkOutput("trapMisalign", {31'b0, Misalign}, 32'd1);
            checkOutput("trapNoReq", {31'b0, imem_req}, 32'd0);
            checkOutput("trapPc", PC, v.expNext);
        end else begin
            checkOutput("reqAfterRetire", {31'b0, imem_req}, 32'd1);
            checkOutput("nextAddr", imem_addr, v.expNext);
            checkOutput("noMisalign", {31'b0, Misalign}, 32'd0);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        checkOutput("rstReq", {31'b0, imem_req}, 32'd0);
        checkOutput("rstValid", {31'b0, InstrValid}, 32'd0);
        checkOutput("rstInstr", Instr, 32'h0);
        checkOutput("rstPc", PC, 32'h0);
        checkOutput("rstMisalign", {31'b0, Misalign}, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        vec_t        v;
        logic [31:0] modelPc;
        logic [31:0] target;

        totalChecks  = 0;
        passedChecks = 0;
        rst          = 1'b1;
        PCSrc        = 1'b0;
        ImmExt       = '0;
        StallD       = 1'b0;
        imem_gnt     = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = '0;

        // word, gntDelay, rvDelay, stall, src, imm, expPC, expNext, expTrap
        tbl[0] = '{32'h0000_0003, 0, 0, 0, 1'b0, 32'h0,         32'h0000_0000, 32'h0000_0004, 1'b0};
        tbl[1] = '{32'h0040_0093, 0, 0, 0, 1'b0, 32'h0,         32'h0000_0004, 32'h0000_0008, 1'b0};
        tbl[2] = '{32'hFE00_0CE3, 0, 0, 0, 1'b1, 32'hFFFF_FFF8, 32'h0000_0008, 32'h0000_0000, 1'b0};
        tbl[3] = '{32'h0000_0013, 0, 0, 0, 1'b0, 32'h0,         32'h0000_0000, 32'h0000_0004, 1'b0};
        tbl[4] = '{32'h0010_8093, 3, 0, 5, 1'b0, 32'h0,         32'h0000_0004, 32'h0000_0008, 1'b0};
        tbl[5] = '{32'h0000_0863, 0, 0, 0, 1'b1, 32'h0000_0010, 32'h0000_0008, 32'h0000_0018, 1'b0};
        tbl[6] = '{32'h0000_0037, 0, 2, 0, 1'b0, 32'h0,         32'h0000_0018, 32'h0000_001C, 1'b0};
        tbl[7] = '{32'h0000_006F, 0, 0, 1, 1'b1, 32'hFFFF_FFE0, 32'h0000_001C, 32'hFFFF_FFFC, 1'b0};
        tbl[8] = '{32'h0000_0017, 1, 1, 0, 1'b0, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 1'b0};

        doReset();
        for (int i = 0; i < 9; i++) applyStimulus(tbl[i]);

        // Reset while waiting for the response; the late response must be dropped.
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst      = 1'b1;
        tick();
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        checkOutput("dropValid", {31'b0, InstrValid}, 32'd0);
        checkOutput("dropInstr", Instr, 32'h0);
        checkOutput("refetchAddr", imem_addr, 32'h0);

        // Retire into a misaligned branch target.
`ifdef MISALIGN_TRAP_EN
        v = '{32'h0020_0063, 0, 0, 0, 1'b1, 32'h2, 32'h0, 32'h2, 1'b1};
        applyStimulus(v);
        for (int i = 0; i < 3; i++) begin
            imem_gnt    = 1'b1;
            imem_rvalid = 1'b1;
            tick();
            checkOutput("trapSticky", {31'b0, Misalign}, 32'd1);
            checkOutput("trapStickyNoReq", {31'b0, imem_req}, 32'd0);
            checkOutput("trapStickyNoValid", {31'b0, InstrValid}, 32'd0);
        end
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
`else
        v = '{32'h0020_0063, 0, 0, 0, 1'b1, 32'h2, 32'h0, 32'h0, 1'b0};
        applyStimulus(v);
`endif
        doReset();

        // Randomized run against the address-arithmetic model.
        modelPc = 32'h0;
        for (int k = 0; k < 40; k++) begin
            v.word        = $urandom;
            v.gntDelay    = $urandom_range(0, 3);
            v.rvDelay     = $urandom_range(0, 3);
            v.stallCycles = $urandom_range(0, 3);
            v.src         = 1'($urandom_range(0, 1));
`ifdef MISALIGN_TRAP_EN
            v.imm         = $urandom & 32'hFFFF_FFFC;
`else
            v.imm         = $urandom;
`endif
            target = v.src ? (modelPc + v.imm) : (modelPc + 32'd4);
            target = target & 32'hFFFF_FFFC;
            v.expPC   = modelPc;
            v.expNext = target;
            v.expTrap = 1'b0;
            applyStimulus(v);
            modelPc = target;
        end

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
